// File: rtl/rvl_pkg.sv
// rtl/rvl_pkg.sv - shared types and constants for the RISC-V-lite fetch stage
package rvl_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer of fetch entries; flush wins over push and pop
module fetch_fifo import rvl_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            wr_en;
    logic            rd_en;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        wr_en    = push && !flush && (!full || pop);
        rd_en    = pop && !flush && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage; optional FETCH_PERF_EN adds perf counters
module fetch_unit import rvl_pkg::*; #(
    parameter int               nbits      = 32,
    parameter logic [nbits-1:0] BOOT_ADDR  = '0,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [nbits-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [nbits-1:0] imem_rdata,
    input  logic             redirect_en,
    input  logic [nbits-1:0] redirect_pc,
    input  logic             id_ready,
`ifdef FETCH_PERF_EN
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt,
`endif
    output logic             if_valid,
    output logic [nbits-1:0] IR_OUT,
    output logic [nbits-1:0] PC_OUT,
    output logic [nbits-1:0] NPC_OUT
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e     fsm_q, fsm_d;
    logic [nbits-1:0] fetch_pc_q, fetch_pc_d;
    logic [nbits-1:0] req_pc_q, req_pc_d;
    logic             outstanding_q, outstanding_d;
    fetch_entry_t     shown_q, shown_d;

    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             fifo_empty;
    logic             unused_fifo_full;
    logic             unused_redirect_lsbs;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      used;
    logic             has_space;
    logic             pop;
    logic             push;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_en),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (unused_fifo_full),
        .count     (fifo_count)
    );

    always_comb begin
        if_valid = !fifo_empty;
        pop      = if_valid && id_ready;
        // A same-cycle rvalid moves an entry from outstanding into the FIFO, so it nets out.
        used      = {1'b0, fifo_count} + (CW+1)'(outstanding_q) - (CW+1)'(pop);
        has_space = (used < (CW+1)'(FIFO_DEPTH));
    end

    always_comb begin
        fsm_d            = fsm_q;
        fetch_pc_d       = fetch_pc_q;
        req_pc_d         = req_pc_q;
        outstanding_d    = outstanding_q;
        imem_req         = 1'b0;
        push             = 1'b0;
        push_entry.instr = imem_rdata;
        push_entry.pc    = req_pc_q;

        case (fsm_q)
            IDLE: fsm_d = REQ;
            REQ: begin
                if (has_space) begin
                    imem_req = 1'b1;
                    if (imem_gnt) begin
                        fetch_pc_d    = fetch_pc_q + nbits'(4);
                        req_pc_d      = fetch_pc_q;
                        outstanding_d = 1'b1;
                        fsm_d         = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push          = 1'b1;
                    outstanding_d = 1'b0;
                    fsm_d         = REQ;
                    if (has_space) begin
                        imem_req = 1'b1;
                        if (imem_gnt) begin
                            fetch_pc_d    = fetch_pc_q + nbits'(4);
                            req_pc_d      = fetch_pc_q;
                            outstanding_d = 1'b1;
                            fsm_d         = WAIT;
                        end
                    end
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    outstanding_d = 1'b0;
                    fsm_d         = REQ;
                end
            end
            default: fsm_d = IDLE;
        endcase

        // Memory still answers a request granted during a redirect, so that one must be dropped too.
        if (redirect_en) begin
            push          = 1'b0;
            fetch_pc_d    = {redirect_pc[nbits-1:2], 2'b00};
            outstanding_d = (outstanding_q && !imem_rvalid) || (imem_req && imem_gnt);
            fsm_d         = outstanding_d ? DISCARD : REQ;
        end
    end

    always_comb begin
        shown_d = fifo_empty ? shown_q : fifo_head;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q         <= IDLE;
            fetch_pc_q    <= BOOT_ADDR;
            req_pc_q      <= BOOT_ADDR;
            outstanding_q <= 1'b0;
            shown_q       <= '{instr: NOP_INSTR, pc: '0};
        end else begin
            fsm_q         <= fsm_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            shown_q       <= shown_d;
        end
    end

    assign imem_addr = fetch_pc_q;
    assign IR_OUT    = fifo_empty ? shown_q.instr : fifo_head.instr;
    assign PC_OUT    = fifo_empty ? shown_q.pc : fifo_head.pc;
    assign NPC_OUT   = PC_OUT + nbits'(4);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(pop);
        perf_stall_d = perf_stall_q + 32'(if_valid && !id_ready);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed, table-driven bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] IR_OUT;
    logic [31:0] PC_OUT;
    logic [31:0] NPC_OUT;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .if_valid       (if_valid),
        .IR_OUT         (IR_OUT),
        .PC_OUT         (PC_OUT),
        .NPC_OUT        (NPC_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        pend     = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        hold_rv  = 1'b0;

    typedef struct {
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at the falling edge: record any grant, then move to just after the next rising edge.
    task automatic edge_step();
        if (rst && imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
        end
        @(posedge clk);
        #1;
        redirect_en = 1'b0;
        if (pend && !hold_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~pend_addr;
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst         = 1'b0;
        pend        = 1'b0;
        hold_rv     = 1'b0;
        imem_rvalid = 1'b0;
        redirect_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        edge_step();
    endtask

    initial begin
        logic        found;
        logic [31:0] exp_pc;

        vecs[0] = '{1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2] = '{1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3] = '{1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4] = '{1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5] = '{1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[6] = '{1'b1, 32'h18, 1'b1, 32'h10};
        vecs[7] = '{1'b1, 32'h1C, 1'b1, 32'h14};

        rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_en = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_ir", IR_OUT, 32'h0000_0013);
        check("rst_pc", PC_OUT, 32'h0);
        check("rst_npc", NPC_OUT, 32'h4);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif

        // Streaming: gnt immediate, rvalid one cycle later, decode always ready.
        rst = 1'b1; id_ready = 1'b1; imem_gnt = 1'b1;
        @(negedge clk);
        check("idle_req", 32'(imem_req), 32'd0);
        edge_step();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("stream%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            check($sformatf("stream%0d_addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("stream%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
            check($sformatf("stream%0d_pc", i), PC_OUT, vecs[i].exp_pc);
            if (vecs[i].exp_valid) begin
                check($sformatf("stream%0d_ir", i), IR_OUT, ~vecs[i].exp_pc);
                check($sformatf("stream%0d_npc", i), NPC_OUT, vecs[i].exp_pc + 32'd4);
            end
            edge_step();
        end

        // Decode stalls for 10 cycles: buffer fills, requests stop, head holds.
        id_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_req", i), 32'(imem_req), 32'd0);
            check($sformatf("stall%0d_pc", i), PC_OUT, 32'h18);
            edge_step();
        end
        id_ready = 1'b1;
        exp_pc   = 32'h18;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
`ifdef FETCH_PERF_EN
            if (i == 0) check("perf_stall", perf_stall_cnt, 32'd10);
`endif
            check($sformatf("drain%0d_valid", i), 32'(if_valid), 32'd1);
            check($sformatf("drain%0d_pc", i), PC_OUT, exp_pc);
            check($sformatf("drain%0d_ir", i), IR_OUT, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
            edge_step();
        end

        // Redirect to 0x100 while the 0x20 request is outstanding.
        apply_reset();
        id_ready = 1'b1; imem_gnt = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h20) begin
                found   = 1'b1;
                hold_rv = 1'b1;
            end
            edge_step();
        end
        check("find_0x20", 32'(found), 32'd1);
        redirect_en = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        check("rd1_req_redirect", 32'(imem_req), 32'd0);
        edge_step();
        @(negedge clk);
        check("rd1_discard_req", 32'(imem_req), 32'd0);
        check("rd1_flush_valid", 32'(if_valid), 32'd0);
        hold_rv = 1'b0;
        edge_step();
        @(negedge clk);
        check("rd1_drop_req", 32'(imem_req), 32'd0);
        check("rd1_drop_valid", 32'(if_valid), 32'd0);
        edge_step();
        @(negedge clk);
        check("rd1_new_req", 32'(imem_req), 32'd1);
        check("rd1_new_addr", imem_addr, 32'h100);
        check("rd1_new_valid", 32'(if_valid), 32'd0);
        edge_step();
        @(negedge clk);
        check("rd1_wait_valid", 32'(if_valid), 32'd0);
        edge_step();
        @(negedge clk);
        check("rd1_arr_valid", 32'(if_valid), 32'd1);
        check("rd1_arr_pc", PC_OUT, 32'h100);
        check("rd1_arr_ir", IR_OUT, ~32'h100);
        edge_step();

        // Redirect + pop + rvalid, new request not granted: straight to REQ.
        repeat (2) begin @(negedge clk); edge_step(); end
        imem_gnt = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        check("rd2_pre_valid", 32'(if_valid), 32'd1);
        edge_step();
        imem_gnt = 1'b1;
        @(negedge clk);
        check("rd2_flush_valid", 32'(if_valid), 32'd0);
        check("rd2_req", 32'(imem_req), 32'd1);
        check("rd2_addr", imem_addr, 32'h200);
        edge_step();
        @(negedge clk);
        check("rd2_wait_valid", 32'(if_valid), 32'd0);
        edge_step();
        @(negedge clk);
        check("rd2_arr_pc", PC_OUT, 32'h200);
        edge_step();

        // Same collision but the new request is granted: its response is discarded.
        redirect_en = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        check("rd3_pre_req", 32'(imem_req), 32'd1);
        edge_step();
        @(negedge clk);
        check("rd3_discard_req", 32'(imem_req), 32'd0);
        check("rd3_flush_valid", 32'(if_valid), 32'd0);
        edge_step();
        @(negedge clk);
        check("rd3_new_addr", imem_addr, 32'h300);
        check("rd3_new_req", 32'(imem_req), 32'd1);
        edge_step();
        @(negedge clk);
        check("rd3_wait_valid", 32'(if_valid), 32'd0);
        edge_step();
        @(negedge clk);
        check("rd3_arr_pc", PC_OUT, 32'h300);
        edge_step();

        // Unaligned redirect near the top of the address space, then wrap.
        imem_gnt = 1'b0; redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        edge_step();
        imem_gnt = 1'b1;
        @(negedge clk);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        edge_step();
        @(negedge clk);
        check("wrap_addr1", imem_addr, 32'h0);
        check("wrap_req1", 32'(imem_req), 32'd1);
        edge_step();
        @(negedge clk);
        check("wrap_pc0", PC_OUT, 32'hFFFF_FFFC);
        check("wrap_npc0", NPC_OUT, 32'h0);
        check("wrap_ir0", IR_OUT, 32'h3);
        edge_step();
        @(negedge clk);
        check("wrap_pc1", PC_OUT, 32'h0);
        check("wrap_npc1", NPC_OUT, 32'h4);
        edge_step();

        // Asynchronous reset while waiting on memory with no room left.
        hold_rv = 1'b1;
        @(negedge clk);
        edge_step();
        id_ready = 1'b0;
        @(negedge clk);
        check("ar_pre_valid", 32'(if_valid), 32'd1);
        check("ar_pre_req", 32'(imem_req), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("ar_req", 32'(imem_req), 32'd0);
        check("ar_addr", imem_addr, 32'h0);
        check("ar_valid", 32'(if_valid), 32'd0);
        check("ar_ir", IR_OUT, 32'h0000_0013);
        check("ar_pc", PC_OUT, 32'h0);
        check("ar_npc", NPC_OUT, 32'h4);
        pend = 1'b0; hold_rv = 1'b0; imem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1; id_ready = 1'b1;
        @(negedge clk);
        check("ar_idle_req", 32'(imem_req), 32'd0);
        edge_step();
        @(negedge clk);
        check("ar_first_req", 32'(imem_req), 32'd1);
        check("ar_first_addr", imem_addr, 32'h0);
        edge_step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RISC-V-lite pipeline, directly upstream of the decode stage. It owns the program counter and issues word fetches to instruction memory over a req/gnt/rvalid handshake. Returned instructions go into a small FIFO, and the FIFO head is presented to decode as IR_OUT/NPC_OUT with a valid/ready handshake. Branch/jump redirects from execute flush the stage and restart fetch at a new PC.

## Interface
- nbits, 32: datapath and address width
- BOOT_ADDR, 32'h0000_0000: PC after reset
- FIFO_DEPTH, 2: instruction buffer entries (power of two, ≥2)
- Reset polarity: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-low
- imem_req  out  1  fetch request valid
- imem_addr  out  nbits  fetch address (word aligned)
- imem_gnt  in  1  request accepted this cycle (when imem_req=1)
- imem_rvalid  in  1  response data valid; exactly one per granted request, ≥1 cycle after gnt, in order
- imem_rdata  in  nbits  fetched instruction
- redirect_en  in  1  flush and restart fetch (from execute)
- redirect_pc  in  nbits  new PC, low 2 bits ignored
- id_ready  in  1  decode accepts instruction this cycle
- if_valid  out  1  IR_OUT/PC_OUT/NPC_OUT valid
- IR_OUT  out  nbits  instruction to decode
- PC_OUT  out  nbits  address of IR_OUT
- NPC_OUT  out  nbits  PC_OUT + 4, to decode NPC_IN
- perf_fetch_cnt  out  32  instructions delivered (FETCH_PERF_EN only)
- perf_stall_cnt  out  32  cycles if_valid=1 && id_ready=0 (FETCH_PERF_EN only)

## Operation
- fetch_pc: next address to request. Requests stay in order, with at most one outstanding (granted, no rvalid yet).
- FSM states: IDLE, REQ, WAIT, DISCARD.
  - IDLE: only in the first cycle after reset release. Always goes to REQ.
  - REQ: drive imem_req=1 with imem_addr=fetch_pc when there is space, i.e. occupancy + outstanding < FIFO_DEPTH. On gnt, fetch_pc += 4 and go to WAIT.
  - WAIT: on rvalid, push {imem_rdata, pc}. In the same cycle, a new request may be issued if there is space (back-to-back). Stay in WAIT if that request is granted, otherwise go to REQ.
  - DISCARD: entered when a redirect occurs while a request is outstanding. The next rvalid is dropped (not pushed), then the FSM goes to REQ. No request is issued while in DISCARD.
- Space check counts the FIFO pop and the rvalid that happen in the same cycle, so one instruction per cycle is sustained when gnt is immediate and rvalid follows one cycle later.
- Pop: if_valid && id_ready.
- Redirect (redirect_en=1):
  - flush the FIFO (occupancy=0, if_valid=0 next cycle);
  - fetch_pc ← {redirect_pc[nbits-1:2], 2'b00};
  - any grant in that cycle is ignored;
  - the FSM goes to DISCARD if a request is outstanding (or an unreturned one was granted that cycle), else to REQ.
  - Redirect beats pop, push and gnt in the same cycle.
- imem_req is held once asserted until gnt or redirect. imem_addr is stable while imem_req=1 and not granted.
- Full FIFO: no request issued. Empty FIFO: if_valid=0; IR_OUT/PC_OUT/NPC_OUT hold their last values.
- Arithmetic: PC increments are modulo 2^nbits, so 0xFFFF_FFFC + 4 → 0. NPC_OUT wraps the same way.

## Timing
- Reset values: imem_req=0, imem_addr=BOOT_ADDR, if_valid=0, IR_OUT=32'h0000_0013 (NOP), PC_OUT=0, NPC_OUT=4, perf counters=0. FSM=IDLE, fetch_pc=BOOT_ADDR.
- First imem_req: second rising edge after rst deasserts.
- Latency: rvalid at edge N → if_valid=1 after edge N (registered push, no combinational bypass).
- Redirect at edge N → first request to the new PC after edge N+1 if nothing was outstanding, otherwise the cycle after the discarded rvalid.
- Reset asserted mid-operation: all state clears immediately. An rvalid arriving after reset release is illegal (memory is reset together with this block).

## Configuration
- FETCH_PERF_EN defined:
  - perf_fetch_cnt increments on every pop;
  - perf_stall_cnt increments on every cycle with if_valid && !id_ready;
  - both wrap at 2^32 and both reset to 0.
- FETCH_PERF_EN undefined: both ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package rvl_pkg: fetch FSM enum (IDLE/REQ/WAIT/DISCARD), NOP_INSTR=32'h0000_0013, the fetch entry struct {instr, pc}.
- Sub-module fetch_fifo: synchronous FIFO of fetch entries with push, pop, flush, occupancy and empty/full; flush beats push and pop.

## Test plan
- Reset release, gnt tied 1, rvalid one cycle after gnt, id_ready=1 → addresses 0,4,8,… on consecutive cycles; one instruction per cycle on IR_OUT after the first; NPC_OUT=PC_OUT+4.
- id_ready=0 for 10 cycles → at most FIFO_DEPTH entries buffered, imem_req drops; on release the instructions come out in order with no loss or duplicate; perf_stall_cnt=10.
- Redirect to 0x100 while a request to 0x20 is outstanding → rvalid for 0x20 dropped, next request addr=0x100, if_valid=0 until the 0x100 instruction arrives.
- Redirect, pop and rvalid in the same cycle → FIFO empty next cycle, no push, FSM enters DISCARD only if a request is still outstanding.
- redirect_pc=0xFFFF_FFFE → fetch 0xFFFF_FFFC, then 0x0000_0000 (wrap); NPC_OUT=0 for the first.
- Async reset asserted while in WAIT with a full FIFO → outputs return to reset values before the next clock edge.
